// File: rtl/tx_byte_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tx_byte_queue: byte FIFO that feeds a UART transmitter one byte at a time.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tx_byte_queue #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_send,
    input  logic          tx_busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [AW:0] C_DEPTH = DEPTH[AW:0];

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_tx_data;
    logic          r_tx_send;
    logic          r_overflow;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_count != '0) && !tx_busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND:      w_state_nxt = WAIT_ACK;
            WAIT_ACK:  if (tx_busy) w_state_nxt = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign w_push = wr_en && ((r_count != C_DEPTH) || w_pop);
    assign w_drop = wr_en && (r_count == C_DEPTH) && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_data  <= 8'h00;
            r_tx_send  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_overflow <= w_drop;
            r_tx_send  <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the popped word is read before a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign count    = r_count;
    assign full     = (r_count == C_DEPTH);
    assign empty    = (r_count == '0);
    assign overflow = r_overflow;
    assign tx_data  = r_tx_data;
    assign tx_send  = r_tx_send;

endmodule
`default_nettype wire

// File: tb/tb_tx_byte_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tx_byte_queue: directed + random stimulus against a queue-based model.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_tx_byte_queue;

    localparam int DEPTH        = 16;
    localparam int AW           = 4;
    localparam int CLKS_PER_BIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic          tx_busy;

    logic          force_busy = 1'b0;
    logic          uart_busy  = 1'b0;
    int            uart_cnt   = 0;
    int            frame_len  = 10 * CLKS_PER_BIT;

    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model: byte queue plus the sender's progress through a transfer
    byte unsigned  mq[$];
    int            m_stage;
    logic [7:0]    m_tx;
    logic          m_send;
    logic          m_ovf;

    always #5 clk = ~clk;

    assign tx_busy = force_busy | uart_busy;

    tx_byte_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy)
    );

    // UART stand-in: busy rises the cycle after it samples tx_send
    always @(posedge clk) begin
        if (uart_cnt == 0) begin
            if (tx_send === 1'b1) begin
                uart_busy <= 1'b1;
                uart_cnt  <= frame_len;
            end
        end else begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) uart_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic wr, input logic [7:0] d, input logic r, input logic busy);
        bit pop;
        if (r) begin
            mq.delete();
            m_stage = 0;
            m_send  = 1'b0;
            m_tx    = 8'h00;
            m_ovf   = 1'b0;
        end else begin
            pop    = (m_stage == 0) && (mq.size() > 0) && !busy;
            m_ovf  = wr && (mq.size() == DEPTH) && !pop;
            m_send = pop;
            if (pop) m_tx = mq.pop_front();
            if (wr && !m_ovf) mq.push_back(d);
            case (m_stage)
                0: if (pop) m_stage = 1;
                1: m_stage = 2;
                2: if (busy) m_stage = 3;
                default: if (!busy) m_stage = 0;
            endcase
        end
    endtask

    task automatic cycle(input logic wr, input logic [7:0] d, input logic r, input logic fb);
        wr_en      = wr;
        wr_data    = d;
        rst        = r;
        force_busy = fb;
        model_step(wr, d, r, fb | uart_busy);
        @(posedge clk);
        #1;
        check("count",    32'(count),    32'(mq.size()));
        check("empty",    32'(empty),    32'(mq.size() == 0));
        check("full",     32'(full),     32'(mq.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("tx_send",  32'(tx_send),  32'(m_send));
        check("tx_data",  32'(tx_data),  32'(m_tx));
    endtask

    function automatic bit all_idle();
        return (mq.size() == 0) && (m_stage == 0) && !uart_busy && (uart_cnt == 0);
    endfunction

    task automatic drain();
        for (int i = 0; i < 3000 && !all_idle(); i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("drain_done", 32'(all_idle()), 32'd1);
    endtask

    initial begin
        logic fb;
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // single byte
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        drain();

        // ordering with realistic frame length
        cycle(1'b1, 8'h53, 1'b0, 1'b0);
        cycle(1'b1, 8'h4F, 1'b0, 1'b0);
        cycle(1'b1, 8'h53, 1'b0, 1'b0);
        drain();

        // fill while transmitter busy, overflow on 17th push
        for (int i = 0; i <= 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        drain();

        // full queue: push in the same cycle as the pop
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b1);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        drain();

        // wrap-around bursts
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
            drain();
        end

        // reset while waiting for the transmitter to finish
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_stage != 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("reached_wait_done", 32'(m_stage), 32'd3);
        check("count_before_rst", 32'(count), 32'd5);
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // random traffic
        fb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) fb = ~fb;
            if ($urandom_range(0, 15) == 0) frame_len = int'($urandom_range(1, 12));
            cycle(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 249) == 0), fb);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
